// File: rtl/alu_cmd_issuer.sv
// Issues one ALU command at a time: latch the request, strobe the ALU, wait out its
// latency, then hold the captured result until the consumer takes it.
module alu_cmd_issuer #(
   parameter int unsigned WIDTH         = 8,
   parameter logic [3:0]  CMD_MUL_INC   = 4'd9,
   parameter logic [3:0]  CMD_MUL_SHIFT = 4'd10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_opa,
   input  logic [WIDTH-1:0]   req_opb,
   input  logic               req_cin,
   input  logic               req_mode,
   input  logic [1:0]         req_inp_valid,
   input  logic [3:0]         req_cmd,
   output logic [WIDTH-1:0]   alu_opa,
   output logic [WIDTH-1:0]   alu_opb,
   output logic               alu_cin,
   output logic               alu_mode,
   output logic [3:0]         alu_cmd,
   output logic [1:0]         alu_inp_valid,
   output logic               alu_ce,
   input  logic [2*WIDTH-1:0] alu_res,
   input  logic               alu_oflow,
   input  logic               alu_cout,
   input  logic               alu_g,
   input  logic               alu_l,
   input  logic               alu_e,
   input  logic               alu_err,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_res,
   output logic [5:0]         rsp_flags,
   output logic [3:0]         rsp_cmd,
   output logic               rsp_mode,
   output logic [7:0]         err_count
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opb_q;
   logic               cin_q, mode_q;
   logic [1:0]         iv_q;
   logic [3:0]         cmd_q;
   logic [1:0]         cnt_q;
   logic [2*WIDTH-1:0] rsp_res_q;
   logic [5:0]         rsp_flags_q;
   logic [3:0]         rsp_cmd_q;
   logic               rsp_mode_q;
   logic [7:0]         err_q;
   logic               is_mul, is_null;

   assign is_null = (iv_q == 2'b00);
   assign is_mul  = mode_q && (iv_q == 2'b11) &&
                    ((cmd_q == CMD_MUL_INC) || (cmd_q == CMD_MUL_SHIFT));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // A null request spends one dead cycle in ISSUE with the ALU strobe suppressed,
   // so its response appears two cycles after acceptance.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_valid) state_d = StIssue;
         StIssue: state_d = is_null ? StResp : StWait;
         StWait:  if (cnt_q == 2'd0) state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready     = (state_q == StIdle) && !RST;
      alu_ce        = ((state_q == StIssue) && !is_null) || (state_q == StWait);
      alu_inp_valid = (state_q == StIssue) ? iv_q : 2'b00;
      rsp_valid     = (state_q == StResp);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         opa_q       <= '0;
         opb_q       <= '0;
         cin_q       <= 1'b0;
         mode_q      <= 1'b0;
         iv_q        <= 2'b00;
         cmd_q       <= 4'd0;
         cnt_q       <= 2'd0;
         rsp_res_q   <= '0;
         rsp_flags_q <= 6'd0;
         rsp_cmd_q   <= 4'd0;
         rsp_mode_q  <= 1'b0;
         err_q       <= 8'd0;
      end else begin
         if ((state_q == StIdle) && req_valid) begin
            opa_q  <= req_opa;
            opb_q  <= req_opb;
            cin_q  <= req_cin;
            mode_q <= req_mode;
            iv_q   <= req_inp_valid;
            cmd_q  <= req_cmd;
         end
         if (state_q == StIssue) begin
            cnt_q <= is_mul ? 2'd2 : 2'd0;
         end else if ((state_q == StWait) && (cnt_q != 2'd0)) begin
            cnt_q <= cnt_q - 2'd1;
         end
         if ((state_q == StIssue) && is_null) begin
            rsp_res_q   <= '0;
            rsp_flags_q <= 6'b100000;
            rsp_cmd_q   <= cmd_q;
            rsp_mode_q  <= mode_q;
         end else if ((state_q == StWait) && (cnt_q == 2'd0)) begin
            rsp_res_q   <= alu_res;
            rsp_flags_q <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
            rsp_cmd_q   <= cmd_q;
            rsp_mode_q  <= mode_q;
         end
         if ((state_q == StResp) && rsp_ready && rsp_flags_q[5] && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
         end
      end
   end

   assign alu_opa   = opa_q;
   assign alu_opb   = opb_q;
   assign alu_cin   = cin_q;
   assign alu_mode  = mode_q;
   assign alu_cmd   = cmd_q;
   assign rsp_res   = rsp_res_q;
   assign rsp_flags = rsp_flags_q;
   assign rsp_cmd   = rsp_cmd_q;
   assign rsp_mode  = rsp_mode_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized bench for alu_cmd_issuer: a small ALU stand-in with realistic latency and
// a transaction-level model of response timing, contents and the error counter.
module tb_alu_cmd_issuer;

   logic        CLK, RST;
   logic        req_valid, req_ready, req_cin, req_mode;
   logic [7:0]  req_opa, req_opb;
   logic [1:0]  req_inp_valid;
   logic [3:0]  req_cmd;
   logic [7:0]  alu_opa, alu_opb;
   logic        alu_cin, alu_mode, alu_ce;
   logic [3:0]  alu_cmd;
   logic [1:0]  alu_inp_valid;
   logic [15:0] alu_res;
   logic        alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err;
   logic        rsp_valid, rsp_ready, rsp_mode;
   logic [15:0] rsp_res;
   logic [5:0]  rsp_flags;
   logic [3:0]  rsp_cmd;
   logic [7:0]  err_count;

   int          n_chk = 0;
   int          n_pass = 0;
   int          err_exp = 0;

   alu_cmd_issuer #(.WIDTH(8), .CMD_MUL_INC(4'd9), .CMD_MUL_SHIFT(4'd10)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin), .req_mode(req_mode),
      .req_inp_valid(req_inp_valid), .req_cmd(req_cmd),
      .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin), .alu_mode(alu_mode),
      .alu_cmd(alu_cmd), .alu_inp_valid(alu_inp_valid), .alu_ce(alu_ce),
      .alu_res(alu_res), .alu_oflow(alu_oflow), .alu_cout(alu_cout), .alu_g(alu_g),
      .alu_l(alu_l), .alu_e(alu_e), .alu_err(alu_err),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
      .rsp_flags(rsp_flags), .rsp_cmd(rsp_cmd), .rsp_mode(rsp_mode),
      .err_count(err_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ALU behaviour: {ERR,OFLOW,COUT,G,L,E, res[15:0]}
   function automatic logic [21:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic ci, input logic md,
                                           input logic [3:0] c);
      logic [15:0] r;
      logic [5:0]  f;
      r = 16'd0;
      f = 6'd0;
      if (c >= 4'd13) begin
         f[5] = 1'b1;
      end else if (md) begin
         case (c)
            4'd0: begin
               r    = {8'd0, a} + {8'd0, b} + {15'd0, ci};
               f[3] = r[8];
            end
            4'd1:    r = {8'd0, a - b};
            4'd8:    f[2:0] = {a > b, a < b, a == b};
            4'd9:    r = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
            4'd10:   r = ({8'd0, a} << 1) * {8'd0, b};
            default: r = {8'd0, a | b};
         endcase
      end else begin
         r = {8'd0, a ^ b};
      end
      return {f, r};
   endfunction

   // ALU stand-in: result is only valid once enough enabled cycles have elapsed
   logic [21:0] garbage, stub_out;
   logic [1:0]  stub_iv, cur_iv;
   int          stub_k, cur_k, stub_lat;

   always @(posedge CLK) garbage <= 22'($urandom);

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         stub_k  <= 0;
         stub_iv <= 2'b00;
      end else if (alu_ce) begin
         if (alu_inp_valid != 2'b00) begin
            stub_k  <= 1;
            stub_iv <= alu_inp_valid;
         end else begin
            stub_k <= stub_k + 1;
         end
      end
   end

   always_comb begin
      cur_iv   = (alu_inp_valid != 2'b00) ? alu_inp_valid : stub_iv;
      cur_k    = (alu_inp_valid != 2'b00) ? 0 : stub_k;
      stub_lat = (alu_mode && cur_iv == 2'b11 && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? 3 : 1;
      stub_out = garbage;
      if (alu_ce && cur_k >= stub_lat)
         stub_out = alu_ref(alu_opa, alu_opb, alu_cin, alu_mode, alu_cmd);
   end

   assign {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_res} = stub_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_reset_outs();
      check("rst_req_ready", req_ready, 0);
      check("rst_alu_ce", alu_ce, 0);
      check("rst_alu_iv", alu_inp_valid, 0);
      check("rst_alu_ops", {alu_opa, alu_opb}, 0);
      check("rst_alu_misc", {alu_cin, alu_mode, alu_cmd}, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_res", rsp_res, 0);
      check("rst_rsp_flags", rsp_flags, 0);
      check("rst_rsp_cmd_mode", {rsp_cmd, rsp_mode}, 0);
      check("rst_err_count", err_count, 0);
   endtask

   // Entered just after a rising edge; returns just after the rsp handshake edge.
   task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic md, input logic [1:0] iv, input logic [3:0] c,
                      input int hold, input logic [15:0] er, input logic [5:0] ef);
      bit mul;
      int ce_last, rsp_k;
      mul     = md && iv == 2'b11 && (c == 4'd9 || c == 4'd10);
      ce_last = (iv == 2'b00) ? 0 : (mul ? 4 : 2);
      rsp_k   = (iv == 2'b00) ? 2 : (mul ? 5 : 3);
      req_valid = 1'b1;
      req_opa = a; req_opb = b; req_cin = ci; req_mode = md; req_inp_valid = iv; req_cmd = c;
      @(negedge CLK);
      check("idle_req_ready", req_ready, 1);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_alu_ce", alu_ce, 0);
      check("err_count", err_count, err_exp);
      @(posedge CLK); #1;
      req_valid = 1'b0;
      req_opa = 8'($urandom); req_opb = 8'($urandom); req_cmd = 4'($urandom);
      req_inp_valid = 2'($urandom); req_mode = 1'($urandom); req_cin = 1'($urandom);
      for (int k = 1; k <= rsp_k + hold; k++) begin
         if (k == rsp_k + hold) rsp_ready = 1'b1;
         @(negedge CLK);
         check("alu_ce", alu_ce, k <= ce_last);
         check("alu_inp_valid", alu_inp_valid, (k == 1) ? iv : 2'b00);
         if (k <= ce_last) begin
            check("alu_ops", {alu_opa, alu_opb}, {a, b});
            check("alu_cmd_mode_cin", {alu_cmd, alu_mode, alu_cin}, {c, md, ci});
         end
         check("rsp_valid", rsp_valid, k >= rsp_k);
         check("busy_req_ready", req_ready, 0);
         if (k >= rsp_k) begin
            check("rsp_res", rsp_res, er);
            check("rsp_flags", rsp_flags, ef);
            check("rsp_cmd_mode", {rsp_cmd, rsp_mode}, {c, md});
         end
         if (k < rsp_k + hold) begin
            @(posedge CLK); #1;
         end
      end
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      if (ef[5] && err_exp < 255) err_exp++;
   endtask

   task automatic rand_txn();
      logic [7:0]  a, b;
      logic        ci, md;
      logic [1:0]  iv;
      logic [3:0]  c;
      logic [21:0] m;
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); md = 1'($urandom);
      iv = 2'($urandom); c = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
         md = 1'b1; iv = 2'b11; c = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd10;
      end
      m = (iv == 2'b00) ? {6'b100000, 16'd0} : alu_ref(a, b, ci, md, c);
      txn(a, b, ci, md, iv, c, $urandom_range(0, 3), m[15:0], m[21:16]);
   endtask

   initial begin
      RST = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_opa = 8'd0; req_opb = 8'd0; req_cin = 1'b0; req_mode = 1'b0;
      req_inp_valid = 2'b00; req_cmd = 4'd0;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outs();
      RST = 1'b0;

      // ADD 0xFF+0x01, MUL_INC 3*4, null request, then a stalled consumer
      txn(8'hFF, 8'h01, 1'b0, 1'b1, 2'b11, 4'd0, 0, 16'h0100, 6'b001000);
      txn(8'd3, 8'd4, 1'b0, 1'b1, 2'b11, 4'd9, 0, 16'd20, 6'b000000);
      txn(8'h5A, 8'hA5, 1'b1, 1'b1, 2'b00, 4'd2, 0, 16'h0000, 6'b100000);
      txn(8'd7, 8'd7, 1'b0, 1'b1, 2'b11, 4'd8, 4, 16'h0000, 6'b000001);

      repeat (150) rand_txn();

      // Reset in the second WAIT cycle of a multiply
      req_valid = 1'b1; req_opa = 8'd9; req_opb = 8'd11; req_cin = 1'b0; req_mode = 1'b1;
      req_inp_valid = 2'b11; req_cmd = 4'd10;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("pre_rst_alu_ce", alu_ce, 1);
      RST = 1'b1;
      #1;
      check_reset_outs();
      err_exp = 0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         check("post_rst_rsp_valid", rsp_valid, 0);
         check("post_rst_alu_ce", alu_ce, 0);
         check("post_rst_req_ready", req_ready, 1);
      end
      @(posedge CLK); #1;

      // 260 error responses: counter must stick at 0xFF
      for (int i = 0; i < 260; i++)
         txn(8'($urandom), 8'($urandom), 1'b0, 1'b1, 2'b00, 4'($urandom), 0, 16'h0000, 6'b100000);
      @(negedge CLK);
      check("err_count_sat", err_count, 8'hFF);
      check("err_count_model", err_count, err_exp);
      check("final_rsp_valid", rsp_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
